// File: rtl/key_event_controller.sv
// key_event_controller: turns debounced key levels into a single round-robin
// stream of PRESS / RELEASE / LONG events with valid/ready and overflow flag.
module key_event_controller #(
  parameter int N_KEYS      = 4,
  parameter int KEY_W       = 2,
  parameter int LONG_CYCLES = 25_000_000,
  parameter int CNT_W       = 25
) (
  input  logic              clock_50,
  input  logic              reset_key,
  input  logic [N_KEYS-1:0] key_level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [KEY_W-1:0]  evt_key,
  output logic [1:0]        evt_type,
  output logic              overflow,
  input  logic              clear_ovf
);
  typedef enum logic [1:0] {S_UP, S_DOWN, S_LONG} state_t;
  localparam logic [1:0] PRESS = 2'd0, RELEASE = 2'd1, LONG_EV = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LONG_CYCLES - 1);
  state_t            state_q [N_KEYS];
  state_t            state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];
  logic [1:0]        new_t [N_KEYS];
  logic [1:0]        slot_t [N_KEYS];
  logic [1:0]        slot_t_d [N_KEYS];
  logic [N_KEYS-1:0] prev_level, rise, fall, new_v, slot_v, slot_v_d, gnt;
  logic [KEY_W-1:0]  ptr, gnt_key;
  logic              gnt_any, load, drop;

  assign rise = key_level & ~prev_level;
  assign fall = ~key_level & prev_level;
  assign load = !evt_valid || evt_ready;

  // Search starts at the round-robin pointer and wraps once around all keys.
  always_comb begin
    gnt_any = 1'b0;
    gnt_key = '0;
    gnt     = '0;
    for (int j = 0; j < N_KEYS; j++)
      if (!gnt_any && slot_v[(int'(ptr) + j) % N_KEYS]) begin
        gnt_any = 1'b1;
        gnt_key = KEY_W'((int'(ptr) + j) % N_KEYS);
      end
    if (load && gnt_any) gnt[gnt_key] = 1'b1;
  end

  always_comb begin
    drop = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      new_v[i]    = 1'b0;
      new_t[i]    = PRESS;
      slot_v_d[i] = slot_v[i] & ~gnt[i];
      slot_t_d[i] = slot_t[i];
      if (rise[i]) begin
        state_d[i] = S_DOWN;
        cnt_d[i]   = '0;
        new_v[i]   = 1'b1;
      end else if (fall[i]) begin
        state_d[i] = S_UP;
        new_v[i]   = 1'b1;
        new_t[i]   = RELEASE;
      end else if (state_q[i] == S_DOWN && key_level[i]) begin
        if (cnt_q[i] == LAST) begin
          state_d[i] = S_LONG;
          new_v[i]   = 1'b1;
          new_t[i]   = LONG_EV;
        end else
          cnt_d[i] = cnt_q[i] + 1'b1;
      end
      // A slot freed by this cycle's grant may take the new event.
      if (new_v[i]) begin
        if (slot_v[i] && !gnt[i])
          drop = 1'b1;
        else begin
          slot_v_d[i] = 1'b1;
          slot_t_d[i] = new_t[i];
        end
      end
    end
  end

  always_ff @(posedge clock_50 or posedge reset_key)
    if (reset_key) begin
      prev_level <= '0;
      slot_v     <= '0;
      ptr        <= '0;
      evt_valid  <= 1'b0;
      evt_key    <= '0;
      evt_type   <= PRESS;
      overflow   <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= S_UP;
        cnt_q[i]   <= '0;
        slot_t[i]  <= PRESS;
      end
    end else begin
      prev_level <= key_level;
      slot_v     <= slot_v_d;
      overflow   <= drop || (overflow && !clear_ovf);
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        slot_t[i]  <= slot_t_d[i];
      end
      if (load) begin
        evt_valid <= gnt_any;
        if (gnt_any) begin
          evt_key  <= gnt_key;
          evt_type <= slot_t[gnt_key];
          ptr      <= (gnt_key == KEY_W'(N_KEYS - 1)) ? '0 : gnt_key + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_key_event_controller.sv
// tb_key_event_controller: directed stimulus with a queue-based scoreboard for
// the key event controller, using a short long-press threshold.
module tb_key_event_controller;
  localparam int PRESS = 0, REL = 1, LNG = 2;
  logic       clock_50 = 1'b0;
  logic       reset_key = 1'b1;
  logic       evt_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic [3:0] key_level = 4'b0000;
  logic       evt_valid, overflow;
  logic [1:0] evt_key, evt_type;
  logic [3:0] exp_q[$];
  int         acc_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  key_event_controller #(.N_KEYS(4), .KEY_W(2), .LONG_CYCLES(8), .CNT_W(4)) dut (
    .clock_50 (clock_50),
    .reset_key(reset_key),
    .key_level(key_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_type (evt_type),
    .overflow (overflow),
    .clear_ovf(clear_ovf)
  );

  always #5 clock_50 = ~clock_50;
  always @(posedge clock_50) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock_50);
    #1;
  endtask

  task automatic expect_evt(input int k, input int t);
    exp_q.push_back(4'((k << 2) | t));
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
    tick(3);
  endtask

  task automatic do_reset();
    reset_key = 1'b1;
    key_level = 4'b0000;
    tick(2);
    exp_q.delete();
    acc_q.delete();
    reset_key = 1'b0;
    tick();
  endtask

  // Monitor: every accepted event is checked against the head of the queue.
  always @(negedge clock_50)
    if (!reset_key && evt_valid && evt_ready) begin
      acc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got key %0d type %0d, required no event", evt_key, evt_type);
      end else
        chk("event{key,type}", int'({evt_key, evt_type}), int'(exp_q.pop_front()));
    end

  initial begin
    int bad;
    evt_ready = 1'b1;
    tick(3);
    chk("reset_valid", int'(evt_valid), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_key_out", int'(evt_key), 0);
    chk("reset_type_out", int'(evt_type), 0);
    reset_key = 1'b0;
    tick(2);
    chk("idle_valid", int'(evt_valid), 0);
    expect_evt(2, PRESS);
    key_level = 4'b0100;
    tick();
    chk("latency_t1_valid", int'(evt_valid), 0);
    tick();
    chk("latency_t2_valid", int'(evt_valid), 1);
    chk("latency_t2_key", int'(evt_key), 2);
    chk("latency_t2_type", int'(evt_type), PRESS);
    key_level = 4'b0000;
    expect_evt(2, REL);
    drain("t1_drain");

    acc_q.delete();
    expect_evt(1, PRESS);
    expect_evt(1, LNG);
    expect_evt(1, REL);
    key_level = 4'b0010;
    tick(20);
    key_level = 4'b0000;
    drain("t2_drain");
    chk("t2_event_count", acc_q.size(), 3);
    if (acc_q.size() >= 2) chk("t2_long_delay", acc_q[1] - acc_q[0], 8);

    do_reset();
    for (int k = 0; k < 4; k++) expect_evt(k, PRESS);
    key_level = 4'b1111;
    tick(5);
    key_level = 4'b0000;
    for (int k = 0; k < 4; k++) expect_evt(k, REL);
    drain("t3_drain");
    chk("t3_event_count", acc_q.size(), 8);
    if (acc_q.size() == 8) begin
      chk("t3_burst1_span", acc_q[3] - acc_q[0], 3);
      chk("t3_burst2_span", acc_q[7] - acc_q[4], 3);
    end

    acc_q.delete();
    expect_evt(0, PRESS);
    expect_evt(0, REL);
    key_level = 4'b0001;
    tick();
    key_level = 4'b0000;
    drain("t5_drain");
    chk("t5_overflow", int'(overflow), 0);
    if (acc_q.size() == 2) chk("t5_back_to_back", acc_q[1] - acc_q[0], 1);

    evt_ready = 1'b0;
    expect_evt(0, PRESS);
    expect_evt(3, PRESS);
    expect_evt(0, REL);
    key_level = 4'b0001;
    tick();
    key_level = 4'b1001;
    tick();
    key_level = 4'b1000;
    tick(2);
    chk("t4_overflow_before", int'(overflow), 0);
    key_level = 4'b0000;
    tick();
    chk("t4_overflow_set", int'(overflow), 1);
    bad = 0;
    repeat (50) begin
      tick();
      if (!(evt_valid && evt_key == 2'd0 && evt_type == 2'(PRESS) && overflow)) bad++;
    end
    chk("t4_stable_cycles_bad", bad, 0);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("t4_overflow_cleared", int'(overflow), 0);
    evt_ready = 1'b1;
    drain("t4_drain");

    evt_ready = 1'b0;
    key_level = 4'b1111;
    tick(3);
    chk("t6_valid_before", int'(evt_valid), 1);
    #2 reset_key = 1'b1;
    #1 chk("t6_async_clear", int'(evt_valid), 0);
    exp_q.delete();
    key_level = 4'b0000;
    tick(2);
    reset_key = 1'b0;
    evt_ready = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (evt_valid) bad++;
    end
    chk("t6_stale_cycles", bad, 0);
    chk("t6_overflow", int'(overflow), 0);
    expect_evt(1, PRESS);
    expect_evt(1, REL);
    key_level = 4'b0010;
    tick();
    key_level = 4'b0000;
    drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
